// File: rtl/mix_columns_engine_if.sv
// Handshake bundle between the round datapath and the MixColumns engine.
// The slave side is the engine; the master side is the upstream/downstream logic.
interface mix_columns_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_mode;
   logic [127:0] data_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
   logic         busy;

   modport slave (
      input  in_valid, in_mode, data_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );

   modport master (
      output in_valid, in_mode, data_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );
endinterface

// File: rtl/mix_columns_engine.sv
// Forward/inverse AES MixColumns over a full 128-bit state, COLS_PER_CYCLE columns per beat.
// Inverse mode pre-conditions each column so that one forward datapath serves both modes.
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   mix_columns_engine_if.slave  bus
);

   localparam int         BEATS     = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state;
   logic [1:0]   cnt;
   logic         mode_q;
   logic [127:0] work_q;
   logic [127:0] work_nxt;
   logic         in_ready_q;
   logic         out_valid_q;
   logic         busy_q;
   logic [127:0] data_out_q;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse = forward applied after a0^=4(a0^a2), a1^=4(a1^a3), a2^=u, a3^=v.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a0, a1, a2, a3, u, v, t;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      if (inv) begin
         u  = xtime(xtime(a0 ^ a2));
         v  = xtime(xtime(a1 ^ a3));
         a0 = a0 ^ u;
         a1 = a1 ^ v;
         a2 = a2 ^ u;
         a3 = a3 ^ v;
      end
      t = a0 ^ a1 ^ a2 ^ a3;
      return {a0 ^ t ^ xtime(a0 ^ a1),
              a1 ^ t ^ xtime(a1 ^ a2),
              a2 ^ t ^ xtime(a2 ^ a3),
              a3 ^ t ^ xtime(a3 ^ a0)};
   endfunction

   // Beat datapath: transform the columns selected by cnt, pass the rest through.
   always_comb begin
      work_nxt = work_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         work_nxt[127 - 32 * (int'(cnt) * COLS_PER_CYCLE + k) -: 32] =
            mix_col(work_q[127 - 32 * (int'(cnt) * COLS_PER_CYCLE + k) -: 32], mode_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         data_out_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  work_q     <= bus.data_in;
                  mode_q     <= bus.in_mode;
                  cnt        <= 2'd0;
                  state      <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               work_q <= work_nxt;
               if (cnt == LAST_BEAT) begin
                  // cnt returns to 0 so the column index never leaves the state
                  cnt         <= 2'd0;
                  data_out_q  <= work_nxt;
                  state       <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: known MixColumns vectors, latency per width,
// backpressure, mid-block reset and mode latching.
module tb_mix_columns_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mix_columns_engine_if bus1 ();
   mix_columns_engine_if bus2 ();
   mix_columns_engine_if bus4 ();

   mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   localparam logic [127:0] ZERO = 128'd0;
   localparam logic [127:0] ONE  = 128'd1;
   localparam logic [127:0] V_A  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] F_A  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V_B  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
   localparam logic [127:0] F_B  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic m, input logic [127:0] d);
      bus1.in_valid = 1'b1;
      bus1.in_mode  = m;
      bus1.data_in  = d;
      tick();
      bus1.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 128'(bus1.out_valid), ZERO);
      chk({tag, "_ir_rise"}, 128'(bus1.in_ready), ONE);
   endtask

   task automatic run(input string tag, input logic m, input logic [127:0] d,
                      input logic [127:0] e);
      int lat;
      accept(m, d);
      chk({tag, "_busy"}, 128'(bus1.busy), ONE);
      chk({tag, "_ir_low"}, 128'(bus1.in_ready), ZERO);
      wait_out(lat);
      chk({tag, "_lat"}, 128'(lat), 128'd4);
      chk({tag, "_data"}, bus1.data_out, e);
      release_out(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, l1, l2, l4;
      logic [127:0] held;

      bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.data_in = '0; bus1.out_ready = 1'b0;
      bus2.in_valid = 1'b0; bus2.in_mode = 1'b0; bus2.data_in = '0; bus2.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.data_in = '0; bus4.out_ready = 1'b0;

      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 128'(bus1.in_ready), ONE);
      chk("rst_out_valid", 128'(bus1.out_valid), ZERO);
      chk("rst_busy", 128'(bus1.busy), ZERO);
      chk("rst_data_out", bus1.data_out, ZERO);

      // out_ready in IDLE must be ignored
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      chk("idle_ordy_ov", 128'(bus1.out_valid), ZERO);
      chk("idle_ordy_ir", 128'(bus1.in_ready), ONE);

      run("fwdA", 1'b0, V_A, F_A);
      run("invA", 1'b1, F_A, V_A);
      run("fwdB", 1'b0, V_B, F_B);
      run("invB", 1'b1, F_B, V_B);

      // Backpressure: DONE stalled for 10 cycles with noisy inputs
      accept(1'b0, V_B);
      wait_out(lat);
      chk("bp_data0", bus1.data_out, F_B);
      held = bus1.data_out;
      for (int i = 0; i < 10; i++) begin
         bus1.in_valid = i[0];
         bus1.data_in  = {4{32'(i) ^ 32'h5a5a_a5a5}};
         bus1.in_mode  = i[1];
         tick();
         chk("bp_data", bus1.data_out, held);
         chk("bp_ov", 128'(bus1.out_valid), ONE);
         chk("bp_ir", 128'(bus1.in_ready), ZERO);
      end
      bus1.in_valid = 1'b0;
      release_out("bp");

      // Reset in the middle of a block
      accept(1'b0, V_A);
      tick();
      tick();
      chk("mid_busy", 128'(bus1.busy), ONE);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_ov", 128'(bus1.out_valid), ZERO);
      chk("mid_rst_data", bus1.data_out, ZERO);
      chk("mid_rst_ir", 128'(bus1.in_ready), ONE);
      chk("mid_rst_busy", 128'(bus1.busy), ZERO);
      run("post_rst", 1'b0, V_A, F_A);

      // Mode latch: inputs wiggle during BUSY, in_valid held high
      accept(1'b1, F_A);
      bus1.in_mode  = 1'b0;
      bus1.in_valid = 1'b1;
      bus1.data_in  = V_B;
      wait_out(lat);
      bus1.in_valid = 1'b0;
      chk("latch_lat", 128'(lat), 128'd4);
      chk("latch_data", bus1.data_out, V_A);
      release_out("latch");

      // Latency for each column width, all three started on the same edge
      bus1.in_valid = 1'b1; bus1.in_mode = 1'b1; bus1.data_in = F_A;
      bus2.in_valid = 1'b1; bus2.in_mode = 1'b1; bus2.data_in = F_A;
      bus4.in_valid = 1'b1; bus4.in_mode = 1'b1; bus4.data_in = F_A;
      tick();
      bus1.in_valid = 1'b0;
      bus2.in_valid = 1'b0;
      bus4.in_valid = 1'b0;
      l1 = 0; l2 = 0; l4 = 0;
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) tick();
         if (bus1.out_valid && l1 == 0) l1 = (c == 0) ? -1 : c;
         if (bus2.out_valid && l2 == 0) l2 = (c == 0) ? -1 : c;
         if (bus4.out_valid && l4 == 0) l4 = (c == 0) ? -1 : c;
      end
      chk("lat_c1", 128'(l1), 128'd4);
      chk("lat_c2", 128'(l2), 128'd2);
      chk("lat_c4", 128'(l4), 128'd1);
      chk("data_c1", bus1.data_out, V_A);
      chk("data_c2", bus2.data_out, V_A);
      chk("data_c4", bus4.data_out, V_A);
      bus1.out_ready = 1'b1;
      bus2.out_ready = 1'b1;
      bus4.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      bus2.out_ready = 1'b0;
      bus4.out_ready = 1'b0;
      chk("rel_c2_ir", 128'(bus2.in_ready), ONE);
      chk("rel_c4_ir", 128'(bus4.in_ready), ONE);

      // Forward on the widest engine as well
      bus4.in_valid = 1'b1; bus4.in_mode = 1'b0; bus4.data_in = V_B;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      chk("c4_fwd_ov", 128'(bus4.out_valid), ONE);
      chk("c4_fwd_data", bus4.data_out, F_B);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
